// File: rtl/coproc0_intc_pkg.sv
// Shared constants and types for the CP0 exception/interrupt controller.
// FSM encodings, the interrupt cause code and the default trap vector live here.
package coproc0_intc_pkg;

    localparam logic [4:0]  CP0_EXC_INT  = 5'd0;

    localparam logic [1:0]  CP0_EIU_IDLE = 2'd0;
    localparam logic [1:0]  CP0_EIU_REQ  = 2'd1;
    localparam logic [1:0]  CP0_EIU_EXC  = 2'd2;

    localparam logic [29:0] CP0_VEC_BASE_DEFAULT = 30'h0000_0020;

    // Cause code and PC captured on entry to REQ, committed to CP0 on ack.
    typedef struct packed {
        logic [4:0]  code;
        logic [29:0] pc;
    } cp0_trap_t;

endpackage

// File: rtl/coproc0_irq_pend.sv
// One pending cell per interrupt channel: sample, optional edge detect with sticky clear.
// Build macro CP0_IRQ_EDGE_EN adds the per-channel edge mode and write-1-to-clear.
module coproc0_irq_pend (
    input  logic clk,
    input  logic nrst,
    input  logic irq,
`ifdef CP0_IRQ_EDGE_EN
    input  logic edge_mode,
    input  logic clr,
`endif
    output logic pend
);

    logic pend_reg;

`ifdef CP0_IRQ_EDGE_EN
    logic prev_reg;

    // A new edge beats a concurrent clear so no interrupt is lost.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_reg <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            prev_reg <= irq;
            if (edge_mode) begin
                if (irq && !prev_reg)
                    pend_reg <= 1'b1;
                else if (clr)
                    pend_reg <= 1'b0;
            end else begin
                pend_reg <= irq;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!nrst)
            pend_reg <= 1'b0;
        else
            pend_reg <= irq;
    end
`endif

    assign pend = pend_reg;

endmodule

// File: rtl/coproc0_intc.sv
// CP0 exception/interrupt controller: pending bits, arbitration and trap request/ack FSM.
// Optional build macro CP0_IRQ_EDGE_EN enables per-channel edge-triggered sticky interrupts.
module coproc0_intc
    import coproc0_intc_pkg::*;
#(
    parameter int          NIRQ     = 8,
    parameter logic [29:0] VEC_BASE = CP0_VEC_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [NIRQ-1:0] irq_i,
    input  logic [NIRQ-1:0] im_i,
    input  logic            ie_i,
    input  logic [29:0]     int_pc_i,
    input  logic            exc_valid_i,
    input  logic [4:0]      exc_code_i,
    input  logic [29:0]     exc_pc_i,
    input  logic            trap_ack_i,
    input  logic            rfe_i,
    input  logic [NIRQ-1:0] pend_clr_i,
`ifdef CP0_IRQ_EDGE_EN
    input  logic [NIRQ-1:0] edge_mode_i,
`endif
    output logic            trap_req_o,
    output logic [29:0]     trap_vec_o,
    output logic            in_exc_o,
    output logic [29:0]     epc_o,
    output logic [4:0]      cause_code_o,
    output logic [NIRQ-1:0] pend_o
);

    logic [1:0]      state_reg, state_next;
    cp0_trap_t       cap_reg, cap_next;
    logic            cap_load;
    logic            commit;
    logic            leave;
    logic            in_exc_reg;
    logic [29:0]     epc_reg;
    logic [4:0]      cause_reg;
    logic [NIRQ-1:0] pend;
    logic            irq_cand;

    genvar gi;
    generate
        for (gi = 0; gi < NIRQ; gi++) begin : g_pend
            coproc0_irq_pend u_pend (
                .clk       (clk),
                .nrst      (nrst),
                .irq       (irq_i[gi]),
`ifdef CP0_IRQ_EDGE_EN
                .edge_mode (edge_mode_i[gi]),
                .clr       (pend_clr_i[gi]),
`endif
                .pend      (pend[gi])
            );
        end
    endgenerate

`ifndef CP0_IRQ_EDGE_EN
    // Level-only build: the clear port exists for register-file compatibility only.
    logic [NIRQ-1:0] unused_pend_clr;
    assign unused_pend_clr = pend_clr_i;
`endif

    assign irq_cand = ie_i && !in_exc_reg && (|(pend & im_i));

    always_comb begin
        state_next    = state_reg;
        cap_load      = 1'b0;
        cap_next.code = CP0_EXC_INT;
        cap_next.pc   = int_pc_i;
        commit        = 1'b0;
        leave         = 1'b0;
        case (state_reg)
            CP0_EIU_IDLE: begin
                // The synchronous exception outranks interrupts, which stay pending.
                if (exc_valid_i) begin
                    state_next    = CP0_EIU_REQ;
                    cap_load      = 1'b1;
                    cap_next.code = exc_code_i;
                    cap_next.pc   = exc_pc_i;
                end else if (irq_cand) begin
                    state_next = CP0_EIU_REQ;
                    cap_load   = 1'b1;
                end
            end
            CP0_EIU_REQ: begin
                if (trap_ack_i) begin
                    state_next = CP0_EIU_EXC;
                    commit     = 1'b1;
                end
            end
            CP0_EIU_EXC: begin
                if (exc_valid_i) begin
                    state_next    = CP0_EIU_REQ;
                    cap_load      = 1'b1;
                    cap_next.code = exc_code_i;
                    cap_next.pc   = exc_pc_i;
                end else if (rfe_i) begin
                    state_next = CP0_EIU_IDLE;
                    leave      = 1'b1;
                end
            end
            default: state_next = CP0_EIU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= CP0_EIU_IDLE;
            cap_reg    <= '0;
            in_exc_reg <= 1'b0;
            epc_reg    <= '0;
            cause_reg  <= CP0_EXC_INT;
        end else begin
            state_reg <= state_next;
            if (cap_load)
                cap_reg <= cap_next;
            // in_exc stays set across a nested fault's REQ phase.
            if (commit) begin
                epc_reg    <= cap_reg.pc;
                cause_reg  <= cap_reg.code;
                in_exc_reg <= 1'b1;
            end else if (leave) begin
                in_exc_reg <= 1'b0;
            end
        end
    end

    // The pipeline stalls while a trap is requested, so it must not raise a new fault.
    a_no_exc_in_req: assert property (@(posedge clk) disable iff (!nrst)
        (state_reg == CP0_EIU_REQ) |-> !exc_valid_i);

    assign trap_req_o   = (state_reg == CP0_EIU_REQ);
    assign trap_vec_o   = VEC_BASE;
    assign in_exc_o     = in_exc_reg;
    assign epc_o        = epc_reg;
    assign cause_code_o = cause_reg;
    assign pend_o       = pend;

endmodule

// File: tb/tb_coproc0_intc.sv
// Self-checking bench for coproc0_intc: directed scenarios plus randomized traffic vs a behavioural model.
// Define CP0_IRQ_EDGE_EN for both bench and RTL to exercise edge-mode channels.
module tb_coproc0_intc;

    logic        clk = 1'b0;
    logic        nrst;
    logic [7:0]  irq, im, pend_clr, edge_mode;
    logic        ie, exc_valid, ack, rfe;
    logic [29:0] int_pc, exc_pc;
    logic [4:0]  exc_code;

    logic        trap_req, in_exc;
    logic [29:0] trap_vec, epc;
    logic [4:0]  cause;
    logic [7:0]  pend;

    int total = 0;
    int bad   = 0;

    typedef enum {M_IDLE, M_WAIT_ACK, M_HANDLER} mphase_t;
    mphase_t     m_ph;
    logic        m_in_exc;
    logic [29:0] m_epc, m_hold_pc;
    logic [4:0]  m_cause, m_hold_code;
    logic [7:0]  m_pend, m_prev;

    always #5 clk = ~clk;

    coproc0_intc #(.NIRQ(8), .VEC_BASE(30'h20)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .irq_i        (irq),
        .im_i         (im),
        .ie_i         (ie),
        .int_pc_i     (int_pc),
        .exc_valid_i  (exc_valid),
        .exc_code_i   (exc_code),
        .exc_pc_i     (exc_pc),
        .trap_ack_i   (ack),
        .rfe_i        (rfe),
        .pend_clr_i   (pend_clr),
`ifdef CP0_IRQ_EDGE_EN
        .edge_mode_i  (edge_mode),
`endif
        .trap_req_o   (trap_req),
        .trap_vec_o   (trap_vec),
        .in_exc_o     (in_exc),
        .epc_o        (epc),
        .cause_code_o (cause),
        .pend_o       (pend)
    );

    // Behavioural reference: what the controller should do at one clock edge given current inputs.
    task automatic model_step();
        bit want_irq;
        if (!nrst) begin
            m_ph = M_IDLE; m_in_exc = 0; m_epc = 0; m_cause = 0;
            m_pend = 0; m_prev = 0; m_hold_code = 0; m_hold_pc = 0;
            return;
        end
        want_irq = ie && !m_in_exc && ((m_pend & im) != 8'h00);
        case (m_ph)
            M_IDLE:
                if (exc_valid) begin
                    m_ph = M_WAIT_ACK; m_hold_code = exc_code; m_hold_pc = exc_pc;
                end else if (want_irq) begin
                    m_ph = M_WAIT_ACK; m_hold_code = 5'd0; m_hold_pc = int_pc;
                end
            M_WAIT_ACK:
                if (ack) begin
                    m_epc = m_hold_pc; m_cause = m_hold_code; m_in_exc = 1; m_ph = M_HANDLER;
                end
            M_HANDLER:
                if (exc_valid) begin
                    m_ph = M_WAIT_ACK; m_hold_code = exc_code; m_hold_pc = exc_pc;
                end else if (rfe) begin
                    m_ph = M_IDLE; m_in_exc = 0;
                end
        endcase
        for (int i = 0; i < 8; i++) begin
            if (edge_mode[i]) begin
                if (irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
                else if (pend_clr[i])     m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = irq[i];
            end
        end
        m_prev = irq;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        exc_valid = 0; ack = 0; rfe = 0; pend_clr = 0;
    endtask

    task automatic test_reset();
        nrst = 0; irq = 8'hFF; im = 8'hFF; ie = 1; int_pc = 30'h0;
        exc_code = 5'd1; exc_pc = 30'h0; edge_mode = 0;
        idle_inputs();
        cycle(); cycle();
        total++;
        if (trap_req !== 1'b0 || in_exc !== 1'b0 || pend !== 8'h00 || epc !== 30'h0 || cause !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: req=%b in_exc=%b pend=%h epc=%h cause=%0d want all zero",
                     trap_req, in_exc, pend, epc, cause);
        end
        total++;
        if (trap_vec !== 30'h20) begin
            bad++; $display("FAIL trap_vec: got %h want 00000020", trap_vec);
        end
        irq = 0; nrst = 1;
        cycle(); cycle();
        $display("reset: outputs cleared, vector %h", trap_vec);
    endtask

    task automatic test_irq_basic();
        irq = 8'h04; im = 8'hFF; ie = 1; int_pc = 30'h100;
        cycle();
        total++;
        if (trap_req !== 1'b0 || pend !== 8'h04) begin
            bad++; $display("FAIL irq_latency1: req=%b pend=%h want req=0 pend=04", trap_req, pend);
        end
        cycle();
        total++;
        if (trap_req !== 1'b1) begin
            bad++; $display("FAIL irq_req: got %b want 1", trap_req);
        end
        ack = 1; irq = 0;
        cycle();
        ack = 0;
        total++;
        if (epc !== 30'h100 || cause !== 5'd0 || in_exc !== 1'b1 || trap_req !== 1'b0) begin
            bad++; $display("FAIL irq_ack: epc=%h cause=%0d in_exc=%b req=%b want 100/0/1/0",
                            epc, cause, in_exc, trap_req);
        end
        cycle();
        rfe = 1;
        cycle();
        rfe = 0;
        total++;
        if (in_exc !== 1'b0) begin
            bad++; $display("FAIL irq_rfe: in_exc=%b want 0", in_exc);
        end
        $display("irq_basic: epc=%h cause=%0d", epc, cause);
    endtask

    task automatic test_exc_wins();
        irq = 8'h01; exc_valid = 1; exc_code = 5'd4; exc_pc = 30'h200; int_pc = 30'h104;
        cycle();
        exc_valid = 0; ack = 1;
        cycle();
        ack = 0;
        total++;
        if (cause !== 5'd4 || epc !== 30'h200) begin
            bad++; $display("FAIL exc_priority: cause=%0d epc=%h want 4/200", cause, epc);
        end
        rfe = 1;
        cycle();
        rfe = 0;
        cycle();
        total++;
        if (trap_req !== 1'b1) begin
            bad++; $display("FAIL exc_then_irq_req: got %b want 1", trap_req);
        end
        ack = 1; irq = 0;
        cycle();
        ack = 0;
        total++;
        if (cause !== 5'd0 || epc !== 30'h104) begin
            bad++; $display("FAIL exc_then_irq_cause: cause=%0d epc=%h want 0/104", cause, epc);
        end
        rfe = 1; cycle(); rfe = 0; cycle();
        $display("exc_wins: second trap cause=%0d", cause);
    endtask

    task automatic test_masking();
        int seen;
        im = 8'hFE; ie = 1; irq = 8'h01;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (trap_req) seen++;
        end
        total++;
        if (seen != 0 || pend !== 8'h01) begin
            bad++; $display("FAIL mask_im: req_cycles=%0d pend=%h want 0/01", seen, pend);
        end
        im = 8'hFF; ie = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (trap_req) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL mask_ie: req_cycles=%0d want 0", seen);
        end
        irq = 0; cycle(); cycle(); ie = 1;
        $display("masking: no trap with im/ie masked");
    endtask

    task automatic test_nested();
        exc_valid = 1; exc_code = 5'd3; exc_pc = 30'h50;
        cycle();
        exc_valid = 0; ack = 1;
        cycle();
        ack = 0; exc_valid = 1; exc_code = 5'd10; exc_pc = 30'h300;
        cycle();
        exc_valid = 0;
        total++;
        if (trap_req !== 1'b1 || in_exc !== 1'b1) begin
            bad++; $display("FAIL nested_req: req=%b in_exc=%b want 1/1", trap_req, in_exc);
        end
        ack = 1;
        cycle();
        ack = 0;
        total++;
        if (epc !== 30'h300 || cause !== 5'd10 || in_exc !== 1'b1) begin
            bad++; $display("FAIL nested_ack: epc=%h cause=%0d in_exc=%b want 300/10/1", epc, cause, in_exc);
        end
        rfe = 1; exc_valid = 1; exc_code = 5'd6; exc_pc = 30'h310;
        cycle();
        rfe = 0; exc_valid = 0;
        total++;
        if (trap_req !== 1'b1 || in_exc !== 1'b1) begin
            bad++; $display("FAIL rfe_vs_exc: req=%b in_exc=%b want 1/1", trap_req, in_exc);
        end
        ack = 1; cycle(); ack = 0;
        total++;
        if (epc !== 30'h310 || cause !== 5'd6) begin
            bad++; $display("FAIL rfe_vs_exc_ack: epc=%h cause=%0d want 310/6", epc, cause);
        end
        rfe = 1; cycle(); rfe = 0; cycle();
        $display("nested: final epc=%h cause=%0d", epc, cause);
    endtask

    task automatic test_reset_mid_req();
        irq = 8'h08; exc_valid = 1; exc_code = 5'd7; exc_pc = 30'h400;
        cycle();
        exc_valid = 0;
        total++;
        if (trap_req !== 1'b1) begin
            bad++; $display("FAIL mid_req_setup: req=%b want 1", trap_req);
        end
        nrst = 0;
        cycle();
        total++;
        if (trap_req !== 1'b0 || in_exc !== 1'b0 || pend !== 8'h00) begin
            bad++; $display("FAIL reset_mid_req: req=%b in_exc=%b pend=%h want 0/0/00", trap_req, in_exc, pend);
        end
        nrst = 1; irq = 0;
        cycle(); cycle();
        $display("reset_mid_req: request dropped");
    endtask

`ifdef CP0_IRQ_EDGE_EN
    task automatic test_edge();
        ie = 0; edge_mode = 8'h02; irq = 8'h02;
        cycle();
        irq = 8'h00;
        cycle(); cycle();
        total++;
        if (pend[1] !== 1'b1) begin
            bad++; $display("FAIL edge_sticky: pend=%h want bit1 set", pend);
        end
        pend_clr = 8'h02;
        cycle();
        pend_clr = 0;
        total++;
        if (pend[1] !== 1'b0) begin
            bad++; $display("FAIL edge_clear: pend=%h want bit1 clear", pend);
        end
        irq = 8'h02; pend_clr = 8'h02;
        cycle();
        pend_clr = 0; irq = 0;
        total++;
        if (pend[1] !== 1'b1) begin
            bad++; $display("FAIL edge_set_beats_clr: pend=%h want bit1 set", pend);
        end
        pend_clr = 8'h02; cycle(); pend_clr = 0; edge_mode = 0; ie = 1; cycle();
        $display("edge: sticky set/clear behaves");
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            nrst      = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
            if ($urandom_range(0, 7) == 0) im  = 8'($urandom);
            ie        = ($urandom_range(0, 3) != 0);
            int_pc    = 30'($urandom);
            exc_valid = (m_ph != M_WAIT_ACK) && ($urandom_range(0, 7) == 0);
            exc_code  = 5'($urandom_range(1, 31));
            exc_pc    = 30'($urandom);
            ack       = ($urandom_range(0, 2) == 0);
            rfe       = ($urandom_range(0, 3) == 0);
            pend_clr  = 8'($urandom);
`ifdef CP0_IRQ_EDGE_EN
            if ($urandom_range(0, 31) == 0) edge_mode = 8'($urandom);
`endif
            cycle();
            total++;
            if (trap_req !== (m_ph == M_WAIT_ACK) || in_exc !== m_in_exc || epc !== m_epc ||
                cause !== m_cause || pend !== m_pend) begin
                bad++;
                $display("FAIL random[%0d]: req=%b in_exc=%b epc=%h cause=%0d pend=%h want req=%b in_exc=%b epc=%h cause=%0d pend=%h",
                         n, trap_req, in_exc, epc, cause, pend,
                         (m_ph == M_WAIT_ACK), m_in_exc, m_epc, m_cause, m_pend);
            end
        end
        nrst = 1; idle_inputs();
        $display("random: 600 cycles compared against model");
    endtask

    initial begin
        test_reset();
        test_irq_basic();
        test_exc_wins();
        test_masking();
        test_nested();
        test_reset_mid_req();
`ifdef CP0_IRQ_EDGE_EN
        test_edge();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
